// File: rtl/dii_package.sv
// Shared DII flit type used by every debug-interconnect endpoint.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

// File: rtl/osd_him_peer_pkg.sv
// State encodings and helpers for the host-side GLIP framing endpoint.
package osd_him_peer_pkg;
  localparam int LEN_W = 5;

  typedef enum logic [1:0] {TX_FILL, TX_DROP, TX_LEN, TX_DATA} tx_state_e;
  typedef enum logic       {RX_LEN, RX_DATA} rx_state_e;

  // GLIP words travel byte-swapped relative to DII flits.
  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction
endpackage

// File: rtl/glip_channel.sv
// 16-bit valid/ready stream toward or from the host interface module.
interface glip_channel;
  logic [15:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/osd_him_peer.sv
// Host-side GLIP endpoint: TX buffers a DII packet then emits length word + flits;
// RX strips the length word and passes flits straight through with zero latency.
module osd_him_peer
  import dii_package::*;
  import osd_him_peer_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  glip_channel.master glip_out,
  glip_channel.slave  glip_in,
  input  dii_flit     dii_in,
  output logic        dii_in_ready,
  output dii_flit     dii_out,
  input  logic        dii_out_ready,
  output logic        err_len0,
  output logic        err_overflow
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

  tx_state_e        r_tx_state, w_tx_next;
  logic [LEN_W-1:0] r_cnt, r_rd, r_len;
  logic [15:0]      r_buf [MAX_LEN];

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= TX_FILL;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_FILL: begin
        if (dii_in.valid) begin
          if (dii_in.last)            w_tx_next = TX_LEN;
          else if (r_cnt == LAST_IDX) w_tx_next = TX_DROP;
        end
      end
      TX_DROP: if (dii_in.valid && dii_in.last) w_tx_next = TX_FILL;
      TX_LEN:  if (glip_out.ready) w_tx_next = TX_DATA;
      TX_DATA: if (glip_out.ready && (r_rd == r_len - 5'd1)) w_tx_next = TX_FILL;
      default: w_tx_next = TX_FILL;
    endcase
  end

  always_comb begin
    dii_in_ready  = 1'b0;
    glip_out.valid = 1'b0;
    glip_out.data  = '0;
    err_overflow   = 1'b0;
    case (r_tx_state)
      TX_FILL: begin
        dii_in_ready = 1'b1;
        err_overflow = dii_in.valid && !dii_in.last && (r_cnt == LAST_IDX);
      end
      TX_DROP: dii_in_ready = 1'b1;
      TX_LEN: begin
        glip_out.valid = 1'b1;
        glip_out.data  = swap16({{(16-LEN_W){1'b0}}, r_len});
      end
      TX_DATA: begin
        glip_out.valid = 1'b1;
        glip_out.data  = swap16(r_buf[r_rd[AW-1:0]]);
      end
      default: dii_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rd  <= '0;
      r_len <= '0;
    end else begin
      case (r_tx_state)
        TX_FILL: begin
          if (dii_in.valid) begin
            if (dii_in.last) begin
              r_len <= r_cnt + 5'd1;
              r_cnt <= '0;
            end else if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        TX_LEN:  if (glip_out.ready) r_rd <= '0;
        TX_DATA: if (glip_out.ready) r_rd <= r_rd + 5'd1;
        default: r_rd <= r_rd;
      endcase
    end
  end

  // Payload storage is never reset; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (r_tx_state == TX_FILL && dii_in.valid) r_buf[r_cnt[AW-1:0]] <= dii_in.data;
  end

  rx_state_e        r_rx_state, w_rx_next;
  logic [LEN_W-1:0] r_rem;
  logic [15:0]      w_rx_swap;
  logic [LEN_W-1:0] w_rx_len;

  assign w_rx_swap = swap16(glip_in.data);
  assign w_rx_len  = w_rx_swap[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= RX_LEN;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_LEN:  if (glip_in.valid && (w_rx_len != '0)) w_rx_next = RX_DATA;
      RX_DATA: if (glip_in.valid && dii_out_ready && (r_rem == '0)) w_rx_next = RX_LEN;
      default: w_rx_next = RX_LEN;
    endcase
  end

  always_comb begin
    glip_in.ready = 1'b1;
    dii_out       = '0;
    err_len0      = 1'b0;
    case (r_rx_state)
      RX_LEN: err_len0 = glip_in.valid && (w_rx_len == '0);
      RX_DATA: begin
        glip_in.ready = dii_out_ready;
        dii_out.valid = glip_in.valid;
        dii_out.last  = (r_rem == '0);
        dii_out.data  = w_rx_swap;
      end
      default: glip_in.ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
    end else if (r_rx_state == RX_LEN) begin
      if (glip_in.valid && (w_rx_len != '0)) r_rem <= w_rx_len - 5'd1;
    end else if (glip_in.valid && dii_out_ready) begin
      r_rem <= r_rem - 5'd1;
    end
  end

endmodule

// File: doc/osd_him_peer.md
OSD_HIM_PEER -- requirements
Module: osd_him_peer

Purpose: host-side endpoint of the length-prefixed, byte-swapped GLIP framing used by the host interface module. Packetizes DII packets into GLIP (length word + flits); depacketizes GLIP into DII packets.

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum flits per TX packet (legal 1..31).
REQ-002 SHALL have clk  input  1  clock.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have glip_out  glip_channel.master  16 data + valid/ready  framed stream toward the HIM.
REQ-005 SHALL have glip_in  glip_channel.slave  16 data + valid/ready  framed stream from the HIM.
REQ-006 SHALL have dii_in  input  dii_flit (data 16, valid, last)  packets to send.
REQ-007 SHALL have dii_in_ready  output  1  flow control for dii_in.
REQ-008 SHALL have dii_out  output  dii_flit  received packets.
REQ-009 SHALL have dii_out_ready  input  1  flow control for dii_out.
REQ-010 SHALL have err_len0  output  1  one-cycle pulse: zero length word received.
REQ-011 SHALL have err_overflow  output  1  one-cycle pulse: TX packet exceeded MAX_LEN.

Function
REQ-012 Byte order SHALL be swapped on every GLIP word: glip[15:8]=dii[7:0], glip[7:0]=dii[15:8], both directions.
REQ-013 TX FSM SHALL have states TX_FILL, TX_DROP, TX_LEN, TX_DATA.
REQ-014 TX_FILL: dii_in_ready=1; accepted flit written to buf[cnt], cnt++; last -> len=cnt+1, go TX_LEN.
REQ-015 TX_FILL: flit accepted at cnt==MAX_LEN-1 without last -> err_overflow pulse same cycle, go TX_DROP, cnt=0.
REQ-016 TX_DROP: dii_in_ready=1, flits discarded, no GLIP output; accepted last -> TX_FILL.
REQ-017 TX_LEN: dii_in_ready=0; glip_out.valid=1, word = swap of {11'b0, len[4:0]}; handshake -> TX_DATA, rd=0.
REQ-018 TX_DATA: glip_out = swap(buf[rd]), valid=1; handshake rd++; handshake at rd==len-1 -> TX_FILL, cnt=0.
REQ-019 Length word SHALL be valid the cycle after the last flit is accepted; glip_out.valid=0 in TX_FILL/TX_DROP.
REQ-020 glip_out.data/valid SHALL hold stable while valid && !ready.
REQ-021 RX FSM SHALL have states RX_LEN, RX_DATA.
REQ-022 RX_LEN: glip_in.ready=1, dii_out.valid=0; len=swap(word)[4:0], upper 11 bits ignored.
REQ-023 RX_LEN: len==0 -> err_len0 pulse, stay RX_LEN; else rem=len-1, go RX_DATA.
REQ-024 RX_DATA: combinational pass-through, zero latency: dii_out.valid=glip_in.valid, data=swap(glip_in.data), last=(rem==0), glip_in.ready=dii_out_ready.
REQ-025 RX_DATA handshake: rem--; handshake with rem==0 -> RX_LEN.
REQ-026 TX and RX paths SHALL be fully independent; simultaneous activity SHALL not stall either.
REQ-027 Single-flit TX packet (valid && last at cnt=0) SHALL yield length word 1 then one data word.

Reset
REQ-028 rst SHALL force TX_FILL, RX_LEN, cnt=rd=rem=0, err pulses 0, dii_in_ready=1, glip_in.ready=1, glip_out.valid=0, dii_out.valid=0.
REQ-029 Reset mid-packet SHALL discard partial packets in both directions; buffer contents need no clearing.

Structure
REQ-030 dii_flit SHALL come from dii_package; no new package types; MAX_LEN is a module parameter.
REQ-031 Buffer SHALL be a local MAX_LEN x 16 register array; no sub-module required.

Verification
REQ-032 TX 3 flits 0x1234,0xABCD,0x00FF(last), ready=1 -> glip_out 0x0300,0x3412,0xCDAB,0xFF00.
REQ-033 RX glip_in 0x0200,0x3412,0x7856, dii_out_ready=1 -> dii_out 0x1234 (last=0), 0x5678 (last=1), zero latency.
REQ-034 RX length word 0x0000 then 0x0100,0xEFBE -> err_len0 one pulse, single flit 0xBEEF last=1.
REQ-035 TX 17-flit packet, MAX_LEN=16 -> err_overflow pulse at 16th flit, no glip_out output, next 2-flit packet emits 0x0200 frame.
REQ-036 Random glip_out.ready / dii_out_ready stalls with concurrent TX+RX -> data stable under stall, no loss, order preserved.
REQ-037 rst asserted mid TX_DATA and mid RX_DATA -> next cycle reset values per REQ-028; following packets framed correctly.
